// File: rtl/input_skew_buffer_if.sv
// Router/array-facing signal bundle for input_skew_buffer.
// ISB_OCCUPANCY_EN adds the occupancy and sticky overflow outputs.
interface input_skew_buffer_if #(
    parameter int ROW_COUNT  = 4,
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 8
);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic                                 i_en;
    logic                                 i_reg_clear;
    logic                                 i_drain;
    logic [ROW_COUNT-1:0][DATA_WIDTH-1:0] i_data;
    logic [ROW_COUNT-1:0]                 i_data_valid;
    logic                                 o_pop_en;
    logic                                 i_pe_ready;
    logic [ROW_COUNT-1:0][DATA_WIDTH-1:0] o_data;
    logic [ROW_COUNT-1:0]                 o_data_valid;
    logic                                 o_empty;
    logic                                 o_drain_done;
`ifdef ISB_OCCUPANCY_EN
    logic [ROW_COUNT-1:0][CNT_W-1:0]      o_occupancy;
    logic [ROW_COUNT-1:0]                 o_overflow;

    modport master (
        output i_en, i_reg_clear, i_drain, i_data, i_data_valid, i_pe_ready,
        input  o_pop_en, o_data, o_data_valid, o_empty, o_drain_done, o_occupancy, o_overflow
    );
    modport slave (
        input  i_en, i_reg_clear, i_drain, i_data, i_data_valid, i_pe_ready,
        output o_pop_en, o_data, o_data_valid, o_empty, o_drain_done, o_occupancy, o_overflow
    );
`else
    modport master (
        output i_en, i_reg_clear, i_drain, i_data, i_data_valid, i_pe_ready,
        input  o_pop_en, o_data, o_data_valid, o_empty, o_drain_done
    );
    modport slave (
        input  i_en, i_reg_clear, i_drain, i_data, i_data_valid, i_pe_ready,
        output o_pop_en, o_data, o_data_valid, o_empty, o_drain_done
    );
`endif
endinterface

// File: rtl/input_skew_buffer.sv
// Per-row FIFOs feeding the PE array west edge as a diagonal (skewed) wavefront.
// Optional ISB_OCCUPANCY_EN exposes per-row occupancy and sticky overflow flags.
module isb_row_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 clear,
    input  logic                                 push,
    input  logic [DATA_WIDTH-1:0]                push_data,
    input  logic                                 pop,
    output logic [DATA_WIDTH-1:0]                pop_data,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]      count,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]      count_next
);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [FIFO_DEPTH-1:0][DATA_WIDTH-1:0] mem;
    logic [PTR_W-1:0]                      wptr, rptr;
    logic                                  wr;

    // A full FIFO still accepts a push when the same cycle pops.
    assign wr       = push && ((count != CNT_W'(FIFO_DEPTH)) || pop);
    assign pop_data = mem[rptr];

    always_comb begin
        count_next = count;
        if (wr && !pop)      count_next = count + 1'b1;
        else if (!wr && pop) count_next = count - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (wr && !clear) mem[wptr] <= push_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (clear) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (wr)  wptr <= wptr + 1'b1;
            if (pop) rptr <= rptr + 1'b1;
            count <= count_next;
        end
    end
endmodule

module input_skew_buffer #(
    parameter int ROW_COUNT  = 4,
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int POP_SLACK  = 2
) (
    input  logic               i_clk,
    input  logic               i_nrst,
    input_skew_buffer_if.slave bus
);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                               state, state_next;
    logic [ROW_COUNT-1:0]                 nonempty, pop, stage_busy, tail_vld;
    logic [ROW_COUNT-1:0][CNT_W-1:0]      count, count_next;
    logic [ROW_COUNT-1:0][DATA_WIDTH-1:0] pop_data, tail_data, data_q;
    logic [ROW_COUNT-1:0]                 valid_q;
    logic                                 pop_en_q, pop_ok, empty, drain_done;

    for (genvar r = 0; r < ROW_COUNT; r++) begin : g_row
        isb_row_fifo #(.DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
            .clk       (i_clk),
            .rst_n     (i_nrst),
            .clear     (bus.i_reg_clear),
            .push      (bus.i_data_valid[r]),
            .push_data (bus.i_data[r]),
            .pop       (pop[r]),
            .pop_data  (pop_data[r]),
            .count     (count[r]),
            .count_next(count_next[r])
        );
        assign nonempty[r] = (count[r] != '0);

        // Row r is delayed by r stages; invalid slots carry zero data.
        if (r == 0) begin : g_direct
            assign tail_vld[r]   = pop[r];
            assign tail_data[r]  = pop[r] ? pop_data[r] : '0;
            assign stage_busy[r] = 1'b0;
        end else begin : g_stages
            logic [r-1:0][DATA_WIDTH-1:0] sd;
            logic [r-1:0]                 sv;
            always_ff @(posedge i_clk or negedge i_nrst) begin
                if (!i_nrst) begin
                    sd <= '0;
                    sv <= '0;
                end else if (bus.i_reg_clear) begin
                    sd <= '0;
                    sv <= '0;
                end else if (bus.i_pe_ready) begin
                    sv[0] <= pop[r];
                    sd[0] <= pop[r] ? pop_data[r] : '0;
                    for (int k = 1; k < r; k++) begin
                        sv[k] <= sv[k-1];
                        sd[k] <= sd[k-1];
                    end
                end
            end
            assign tail_vld[r]   = sv[r-1];
            assign tail_data[r]  = sd[r-1];
            assign stage_busy[r] = |sv;
        end
    end

    assign empty = !(|nonempty) && !(|stage_busy) && !(|valid_q);

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst)               state <= IDLE;
        else if (bus.i_reg_clear)  state <= IDLE;
        else                       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.i_drain) state_next = DRAIN;
                     else if (bus.i_en) state_next = RUN;
            RUN:     if (bus.i_drain) state_next = DRAIN;
                     else if (!bus.i_en) state_next = IDLE;
            DRAIN:   if (empty) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // RUN pops only complete wavefronts; DRAIN pops whatever rows hold data.
    always_comb begin
        pop        = '0;
        drain_done = (state == DONE);
        if (bus.i_pe_ready) begin
            if (state == RUN && (&nonempty)) pop = '1;
            else if (state == DRAIN)         pop = nonempty;
        end
    end

    always_comb begin
        pop_ok = 1'b1;
        for (int r = 0; r < ROW_COUNT; r++)
            if (count_next[r] > CNT_W'(FIFO_DEPTH - POP_SLACK)) pop_ok = 1'b0;
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            pop_en_q <= 1'b0;
            data_q   <= '0;
            valid_q  <= '0;
        end else if (bus.i_reg_clear) begin
            pop_en_q <= 1'b0;
            data_q   <= '0;
            valid_q  <= '0;
        end else begin
            pop_en_q <= pop_ok;
            if (bus.i_pe_ready) begin
                valid_q <= tail_vld;
                data_q  <= tail_data;
            end
        end
    end

    assign bus.o_pop_en     = pop_en_q;
    assign bus.o_data       = data_q;
    assign bus.o_data_valid = valid_q;
    assign bus.o_empty      = empty;
    assign bus.o_drain_done = drain_done;

`ifdef ISB_OCCUPANCY_EN
    logic [ROW_COUNT-1:0] overflow_q, drop;

    always_comb begin
        for (int r = 0; r < ROW_COUNT; r++)
            drop[r] = bus.i_data_valid[r] && (count[r] == CNT_W'(FIFO_DEPTH)) && !pop[r];
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst)              overflow_q <= '0;
        else if (bus.i_reg_clear) overflow_q <= '0;
        else                      overflow_q <= overflow_q | drop;
    end

    assign bus.o_occupancy = count;
    assign bus.o_overflow  = overflow_q;
`endif
endmodule

// File: tb/tb_input_skew_buffer.sv
// Directed self-checking bench for input_skew_buffer (4 rows, 8-bit, depth 8).
module tb_input_skew_buffer;
    localparam int RC = 4;
    localparam int DW = 8;
    localparam int FD = 8;

    logic i_clk = 1'b0;
    logic i_nrst;
    int   n_chk = 0;
    int   n_err = 0;

    input_skew_buffer_if #(.ROW_COUNT(RC), .DATA_WIDTH(DW), .FIFO_DEPTH(FD)) bus ();

    input_skew_buffer #(.ROW_COUNT(RC), .DATA_WIDTH(DW), .FIFO_DEPTH(FD), .POP_SLACK(2)) dut (
        .i_clk (i_clk),
        .i_nrst(i_nrst),
        .bus   (bus)
    );

    always #5 i_clk = ~i_clk;

    logic [DW-1:0] got [RC][$];
    int done_cnt, frz_err, last_vld_cyc, done_cyc, bad;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic clr_log();
        for (int r = 0; r < RC; r++) got[r].delete();
        done_cnt = 0; frz_err = 0; last_vld_cyc = -1; done_cyc = -1;
    endtask

    // Runs n cycles with ready from pat (bit i = cycle i), logging every value the array takes.
    task automatic collect(input int n, input logic [31:0] pat);
        logic [RC-1:0][DW-1:0] pd;
        logic [RC-1:0]         pv;
        for (int i = 0; i < n; i++) begin
            bus.i_pe_ready = (i < 32) ? pat[i] : 1'b1;
            pd = bus.o_data;
            pv = bus.o_data_valid;
            step();
            if (bus.i_pe_ready) begin
                for (int r = 0; r < RC; r++)
                    if (bus.o_data_valid[r]) begin
                        got[r].push_back(bus.o_data[r]);
                        last_vld_cyc = i;
                    end
            end else if (bus.o_data !== pd || bus.o_data_valid !== pv) begin
                frz_err++;
            end
            if (bus.o_drain_done) begin
                done_cnt++;
                done_cyc = i;
            end
        end
        bus.i_pe_ready = 1'b1;
    endtask

    function automatic int total_got();
        int t = 0;
        for (int r = 0; r < RC; r++) t += got[r].size();
        return t;
    endfunction

    initial begin
        i_nrst           = 1'b0;
        bus.i_en         = 1'b0;
        bus.i_reg_clear  = 1'b0;
        bus.i_drain      = 1'b0;
        bus.i_data       = '0;
        bus.i_data_valid = '0;
        bus.i_pe_ready   = 1'b1;
        clr_log();

        // Reset state
        #22;
        chk("rst_empty", bus.o_empty, 1);
        chk("rst_valid", bus.o_data_valid, 0);
        chk("rst_data", bus.o_data, 0);
        chk("rst_pop_en", bus.o_pop_en, 0);
        chk("rst_done", bus.o_drain_done, 0);
        i_nrst = 1'b1;
        step();
        chk("pop_en_after_rst", bus.o_pop_en, 1);

        // Skew: one full wavefront emerges diagonally
        bus.i_en = 1'b1;
        step();
        for (int r = 0; r < RC; r++) bus.i_data[r] = DW'(16 * (r + 1));
        bus.i_data_valid = '1;
        step();
        bus.i_data_valid = '0;
        chk("skew_c1_valid", bus.o_data_valid, 0);
        for (int k = 1; k <= RC; k++) begin
            step();
            chk($sformatf("skew_c%0d_valid", k + 1), bus.o_data_valid, 64'(1 << (k - 1)));
            chk($sformatf("skew_c%0d_data", k + 1), bus.o_data[k-1], 64'(16 * k));
        end
        step();
        chk("skew_end_valid", bus.o_data_valid, 0);
        chk("skew_end_empty", bus.o_empty, 1);

        // Alignment: row 0 alone never issues
        for (int k = 1; k <= 3; k++) begin
            bus.i_data[0] = DW'(8'hA0 + k);
            bus.i_data_valid = 4'b0001;
            step();
        end
        bus.i_data_valid = '0;
        clr_log();
        collect(4, '1);
        chk("align_no_issue", total_got(), 0);
        chk("align_not_empty", bus.o_empty, 0);
        for (int r = 1; r < RC; r++) bus.i_data[r] = DW'(8'hB0 + r);
        bus.i_data_valid = 4'b1110;
        step();
        bus.i_data_valid = '0;
        clr_log();
        collect(8, '1);
        for (int r = 0; r < RC; r++) chk($sformatf("align_row%0d_cnt", r), got[r].size(), 1);
        chk("align_row0_data", got[0][0], 8'hA1);
        chk("align_row3_data", got[3][0], 8'hB3);

        // Drain: row 0 holds A2,A3
        bus.i_drain = 1'b1;
        step();
        bus.i_drain = 1'b0;
        bus.i_en    = 1'b0;
        clr_log();
        collect(12, '1);
        chk("drain_row0_cnt", got[0].size(), 2);
        chk("drain_row0_d0", got[0][0], 8'hA2);
        chk("drain_row0_d1", got[0][1], 8'hA3);
        chk("drain_others", got[1].size() + got[2].size() + got[3].size(), 0);
        chk("drain_done_cnt", done_cnt, 1);
        chk("drain_done_after", done_cyc > last_vld_cyc, 1);
        chk("drain_empty", bus.o_empty, 1);

        // IDLE after drain: a full wavefront waits
        for (int r = 0; r < RC; r++) bus.i_data[r] = DW'(8'hC0 + r);
        bus.i_data_valid = '1;
        step();
        bus.i_data_valid = '0;
        clr_log();
        collect(4, '1);
        chk("idle_no_issue", total_got(), 0);
        chk("idle_not_empty", bus.o_empty, 0);

        // Clear overrides a same-cycle push
        bus.i_reg_clear  = 1'b1;
        bus.i_data_valid = '1;
        step();
        bus.i_reg_clear  = 1'b0;
        bus.i_data_valid = '0;
        chk("clr_empty", bus.o_empty, 1);
        chk("clr_pop_en", bus.o_pop_en, 0);
        step();
        chk("clr_pop_en_next", bus.o_pop_en, 1);
        bus.i_en = 1'b1;
        clr_log();
        collect(6, '1);
        chk("clr_no_data", total_got(), 0);

        // Backpressure: fill to 8 with ready low, then push+pop on full
        bus.i_pe_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            for (int r = 0; r < RC; r++) bus.i_data[r] = DW'((r + 1) * 16 + k);
            bus.i_data_valid = '1;
            step();
            if (k == 5) chk("bp_pop_en_6", bus.o_pop_en, 1);
            if (k == 6) chk("bp_pop_en_7", bus.o_pop_en, 0);
        end
        chk("bp_frozen_valid", bus.o_data_valid, 0);
        clr_log();
        for (int r = 0; r < RC; r++) bus.i_data[r] = DW'((r + 1) * 16 + 8);
        bus.i_pe_ready = 1'b1;
        step();
        bus.i_data_valid = '0;
        for (int r = 0; r < RC; r++)
            if (bus.o_data_valid[r]) got[r].push_back(bus.o_data[r]);
        collect(24, 32'hFFFF_FFF3);
        bad = 0;
        for (int r = 0; r < RC; r++) begin
            chk($sformatf("bp_row%0d_cnt", r), got[r].size(), 9);
            for (int k = 0; k < got[r].size() && k < 9; k++)
                if (got[r][k] !== DW'((r + 1) * 16 + k)) bad++;
        end
        chk("bp_data_order", bad, 0);
        chk("bp_freeze", frz_err, 0);
        chk("bp_pop_en_back", bus.o_pop_en, 1);
        chk("bp_empty", bus.o_empty, 1);

        // Dropped push: 9 pushes into row 2 while idle
        bus.i_en = 1'b0;
        step();
        for (int k = 0; k < 9; k++) begin
            bus.i_data[2] = DW'(8'h50 + k);
            bus.i_data_valid = 4'b0100;
            step();
        end
        bus.i_data_valid = '0;
`ifdef ISB_OCCUPANCY_EN
        chk("ovf_occ2", bus.o_occupancy[2], 8);
        chk("ovf_flag", bus.o_overflow, 4'b0100);
`endif
        for (int r = 0; r < RC; r++) bus.i_data[r] = DW'(8'h60 + r);
        bus.i_data_valid = 4'b1011;
        step();
        bus.i_data_valid = '0;
        bus.i_drain = 1'b1;
        step();
        bus.i_drain = 1'b0;
        clr_log();
        collect(24, '1);
        chk("drop_row2_cnt", got[2].size(), 8);
        bad = 0;
        for (int k = 0; k < got[2].size() && k < 8; k++)
            if (got[2][k] !== DW'(8'h50 + k)) bad++;
        chk("drop_row2_data", bad, 0);
        chk("drop_row0_cnt", got[0].size(), 1);
        chk("drop_row3_data", got[3].size() > 0 ? got[3][0] : 8'h00, 8'h63);
        chk("drop_done_cnt", done_cnt, 1);
`ifdef ISB_OCCUPANCY_EN
        chk("ovf_sticky", bus.o_overflow[2], 1);
        bus.i_reg_clear = 1'b1;
        step();
        bus.i_reg_clear = 1'b0;
        chk("ovf_clr_flag", bus.o_overflow, 0);
        chk("ovf_clr_occ", bus.o_occupancy, 0);
`endif

        // Reset in the middle of a drain: no done pulse
        for (int k = 0; k < 2; k++) begin
            bus.i_data[0] = DW'(8'hE0 + k);
            bus.i_data_valid = 4'b0001;
            step();
        end
        bus.i_data_valid = '0;
        bus.i_drain = 1'b1;
        step();
        bus.i_drain = 1'b0;
        step();
        i_nrst = 1'b0;
        #1;
        chk("mid_rst_empty", bus.o_empty, 1);
        chk("mid_rst_valid", bus.o_data_valid, 0);
        #2;
        i_nrst = 1'b1;
        clr_log();
        collect(10, '1);
        chk("mid_rst_no_done", done_cnt, 0);
        chk("mid_rst_no_data", total_got(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
